// File: rtl/tawas_rcn_ldq.sv
// Per-slice load queue: one outstanding bus read per slice, round-robin issue, registered write-back.
// Define TAWAS_RCN_LDQ_TIMEOUT_EN to force-complete reads that get no response within TIMEOUT cycles.
module tawas_rcn_ldq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VLD,
    input  logic [1:0]  REQ_SLICE,
    input  logic [3:0]  REQ_SEL,
    input  logic [31:0] REQ_ADDR,
    output logic        REQ_BUSY,
    output logic [3:0]  SLICE_PEND,
    output logic        RD_VLD,
    output logic [1:0]  RD_TAG,
    output logic [31:0] RD_ADDR,
    input  logic        RD_ACK,
    input  logic        RSP_VLD,
    input  logic [1:0]  RSP_TAG,
    input  logic [31:0] RSP_DATA,
    output logic        RCN_LOAD_VLD,
    output logic [1:0]  RCN_LOAD_SLICE,
    output logic [3:0]  RCN_LOAD_SEL,
    output logic [31:0] RCN_LOAD,
    output logic        ERR_BUSY,
    output logic        ERR_SPUR,
    output logic        ERR_TO
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait} ent_st_e;

    ent_st_e     st_q [4];
    ent_st_e     st_d [4];
    logic [3:0]  sel_q [4];
    logic [31:0] addr_q [4];
    logic [1:0]  rr_q;
    logic [1:0]  gnt_q;
    logic        lock_q;
    logic [1:0]  gnt;
    logic [1:0]  idx;
    logic        rd_fire;
    logic        req_take;
    logic        rsp_hit;
    logic        load_vld_d;
    logic [1:0]  load_slice_d;
    logic [3:0]  load_sel_d;
    logic [31:0] load_d;
    logic        err_busy_d;
    logic        err_spur_d;

    assign REQ_BUSY = (st_q[REQ_SLICE] != StIdle);
    assign req_take = REQ_VLD && !REQ_BUSY;
    assign rsp_hit  = RSP_VLD && (st_q[RSP_TAG] == StWait);

    always_comb begin
        SLICE_PEND = '0;
        RD_VLD     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            SLICE_PEND[i] = (st_q[i] != StIdle);
            if (st_q[i] == StIssue) RD_VLD = 1'b1;
        end
    end

    // Grant is frozen while a presented read awaits RD_ACK so a newly issued entry cannot steal it.
    always_comb begin
        gnt = lock_q ? gnt_q : rr_q;
        idx = rr_q;
        if (!lock_q) begin
            for (int i = 3; i >= 0; i--) begin
                idx = rr_q + 2'(i);
                if (st_q[idx] == StIssue) gnt = idx;
            end
        end
    end

    assign RD_TAG  = gnt;
    assign RD_ADDR = addr_q[gnt];
    assign rd_fire = RD_VLD && RD_ACK;

`ifdef TAWAS_RCN_LDQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 2);

    logic [CntW-1:0] cnt_q [4];
    logic [3:0]      expired;
    logic            to_fire;
    logic [1:0]      to_slice;
    logic            err_to_q;

    // A valid response owns the write-back slot; expired entries stay saturated and retry.
    always_comb begin
        expired  = '0;
        to_slice = '0;
        for (int i = 3; i >= 0; i--) begin
            expired[i] = (st_q[i] == StWait) && (cnt_q[i] >= CntW'(TIMEOUT - 1));
            if (expired[i]) to_slice = 2'(i);
        end
        to_fire = (|expired) && !rsp_hit;
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (!RST_N) begin
                cnt_q[i] <= '0;
            end else if (rd_fire && (gnt == 2'(i))) begin
                cnt_q[i] <= '0;
            end else if ((st_q[i] == StWait) && (cnt_q[i] < CntW'(TIMEOUT))) begin
                cnt_q[i] <= cnt_q[i] + CntW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) err_to_q <= 1'b0;
        else if (to_fire) err_to_q <= 1'b1;
    end

    assign ERR_TO = err_to_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign ERR_TO = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) st_d[i] = st_q[i];
        load_vld_d   = 1'b0;
        load_slice_d = RCN_LOAD_SLICE;
        load_sel_d   = RCN_LOAD_SEL;
        load_d       = RCN_LOAD;
        err_busy_d   = ERR_BUSY | (REQ_VLD & REQ_BUSY);
        err_spur_d   = ERR_SPUR | (RSP_VLD & !rsp_hit);
        if (req_take) st_d[REQ_SLICE] = StIssue;
        if (rd_fire) st_d[gnt] = StWait;
        if (rsp_hit) begin
            load_vld_d       = 1'b1;
            load_slice_d     = RSP_TAG;
            load_sel_d       = sel_q[RSP_TAG];
            load_d           = RSP_DATA;
            st_d[RSP_TAG]    = StIdle;
        end
`ifdef TAWAS_RCN_LDQ_TIMEOUT_EN
        if (to_fire) begin
            load_vld_d       = 1'b1;
            load_slice_d     = to_slice;
            load_sel_d       = sel_q[to_slice];
            load_d           = '1;
            st_d[to_slice]   = StIdle;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]   <= StIdle;
                sel_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            rr_q           <= '0;
            gnt_q          <= '0;
            lock_q         <= 1'b0;
            RCN_LOAD_VLD   <= 1'b0;
            RCN_LOAD_SLICE <= '0;
            RCN_LOAD_SEL   <= '0;
            RCN_LOAD       <= '0;
            ERR_BUSY       <= 1'b0;
            ERR_SPUR       <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) st_q[i] <= st_d[i];
            if (req_take) begin
                sel_q[REQ_SLICE]  <= REQ_SEL;
                addr_q[REQ_SLICE] <= REQ_ADDR;
            end
            if (rd_fire) rr_q <= gnt + 2'd1;
            gnt_q          <= gnt;
            lock_q         <= RD_VLD && !RD_ACK;
            RCN_LOAD_VLD   <= load_vld_d;
            RCN_LOAD_SLICE <= load_slice_d;
            RCN_LOAD_SEL   <= load_sel_d;
            RCN_LOAD       <= load_d;
            ERR_BUSY       <= err_busy_d;
            ERR_SPUR       <= err_spur_d;
        end
    end

endmodule

// File: tb/tb_tawas_rcn_ldq.sv
// Scoreboard bench for tawas_rcn_ldq: directed scenarios then random traffic against a slice-level model.
// Define TAWAS_RCN_LDQ_TIMEOUT_EN for both files to exercise the timeout path.
module tb_tawas_rcn_ldq;
    localparam int unsigned TO = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_VLD = 1'b0;
    logic [1:0]  REQ_SLICE = '0;
    logic [3:0]  REQ_SEL = '0;
    logic [31:0] REQ_ADDR = '0;
    logic        REQ_BUSY;
    logic [3:0]  SLICE_PEND;
    logic        RD_VLD;
    logic [1:0]  RD_TAG;
    logic [31:0] RD_ADDR;
    logic        RD_ACK = 1'b0;
    logic        RSP_VLD = 1'b0;
    logic [1:0]  RSP_TAG = '0;
    logic [31:0] RSP_DATA = '0;
    logic        RCN_LOAD_VLD;
    logic [1:0]  RCN_LOAD_SLICE;
    logic [3:0]  RCN_LOAD_SEL;
    logic [31:0] RCN_LOAD;
    logic        ERR_BUSY;
    logic        ERR_SPUR;
    logic        ERR_TO;

    always #5 CLK = ~CLK;

    tawas_rcn_ldq #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VLD(REQ_VLD), .REQ_SLICE(REQ_SLICE), .REQ_SEL(REQ_SEL), .REQ_ADDR(REQ_ADDR),
        .REQ_BUSY(REQ_BUSY), .SLICE_PEND(SLICE_PEND),
        .RD_VLD(RD_VLD), .RD_TAG(RD_TAG), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK),
        .RSP_VLD(RSP_VLD), .RSP_TAG(RSP_TAG), .RSP_DATA(RSP_DATA),
        .RCN_LOAD_VLD(RCN_LOAD_VLD), .RCN_LOAD_SLICE(RCN_LOAD_SLICE),
        .RCN_LOAD_SEL(RCN_LOAD_SEL), .RCN_LOAD(RCN_LOAD),
        .ERR_BUSY(ERR_BUSY), .ERR_SPUR(ERR_SPUR), .ERR_TO(ERR_TO)
    );

    typedef struct {
        logic [1:0]  slice;
        logic [3:0]  sel;
        logic [31:0] data;
        int          due;
    } wb_t;

    wb_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          mon_exp;
    wb_t         mon_e;
    logic [1:0]  last_slice = '0;
    logic [3:0]  last_sel = '0;
    logic [31:0] last_data = '0;

    // Slice-level model: 0 idle, 1 waiting to issue, 2 waiting for response.
    int          m_st[4];
    logic [3:0]  m_sel[4];
    logic [31:0] m_addr[4];
    int          m_enter[4];
    int          m_rr;
    bit          m_hold;
    int          m_hold_gnt;
    bit          m_eb, m_es, m_et;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_st[k] = 0; m_sel[k] = '0; m_addr[k] = '0; m_enter[k] = 0;
        end
        m_rr = 0; m_hold = 1'b0; m_hold_gnt = 0;
        m_eb = 1'b0; m_es = 1'b0; m_et = 1'b0;
    endtask

    // Write-back monitor: registered port, so an expected item must appear exactly on its due cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            mon_exp = (sb.size() > 0) && (sb[0].due == cyc);
            chk("wb_vld", RCN_LOAD_VLD, mon_exp);
            if (mon_exp) begin
                mon_e = sb.pop_front();
                chk("wb_slice", RCN_LOAD_SLICE, mon_e.slice);
                chk("wb_sel", RCN_LOAD_SEL, mon_e.sel);
                chk("wb_data", RCN_LOAD, mon_e.data);
                last_slice = mon_e.slice; last_sel = mon_e.sel; last_data = mon_e.data;
            end else begin
                chk("wb_hold_slice", RCN_LOAD_SLICE, last_slice);
                chk("wb_hold_sel", RCN_LOAD_SEL, last_sel);
                chk("wb_hold_data", RCN_LOAD, last_data);
            end
        end
    end

    task automatic step(input logic rst_n, input logic rv, input logic [1:0] rs,
                        input logic [3:0] rsel, input logic [31:0] ra, input logic ack,
                        input logic pv, input logic [1:0] pt, input logic [31:0] pd);
        int  nx[4];
        int  g;
        int  c;
        bit  ev;
        bit  hit;
        wb_t e;
        @(negedge CLK);
        RST_N = rst_n; REQ_VLD = rv; REQ_SLICE = rs; REQ_SEL = rsel; REQ_ADDR = ra;
        RD_ACK = ack; RSP_VLD = pv; RSP_TAG = pt; RSP_DATA = pd;
        #1;
        ev = 1'b0;
        g  = 0;
        for (int k = 0; k < 4; k++) if (m_st[k] == 1) ev = 1'b1;
        if (m_hold) g = m_hold_gnt;
        else for (int k = 3; k >= 0; k--) if (m_st[(m_rr + k) % 4] == 1) g = (m_rr + k) % 4;
        chk("req_busy", REQ_BUSY, m_st[rs] != 0);
        for (int k = 0; k < 4; k++) chk("slice_pend", SLICE_PEND[k], m_st[k] != 0);
        chk("rd_vld", RD_VLD, ev);
        if (ev) begin
            chk("rd_tag", RD_TAG, g);
            chk("rd_addr", RD_ADDR, m_addr[g]);
        end
        chk("err_busy", ERR_BUSY, m_eb);
        chk("err_spur", ERR_SPUR, m_es);
        chk("err_to", ERR_TO, m_et);
        if (!rst_n) begin
            model_reset();
            sb.delete();
            last_slice = '0; last_sel = '0; last_data = '0;
        end else begin
            nx = m_st;
            if (rv) begin
                if (m_st[rs] == 0) begin
                    nx[rs] = 1; m_sel[rs] = rsel; m_addr[rs] = ra;
                end else m_eb = 1'b1;
            end
            if (ev && ack) begin
                nx[g] = 2; m_enter[g] = cyc; m_rr = (g + 1) % 4; m_hold = 1'b0;
            end else begin
                m_hold = ev; m_hold_gnt = g;
            end
            hit = pv && (m_st[pt] == 2);
            if (pv && !hit) m_es = 1'b1;
            if (hit) begin
                e.slice = pt; e.sel = m_sel[pt]; e.data = pd; e.due = cyc + 1;
                sb.push_back(e);
                nx[pt] = 0;
            end
            c = -1;
`ifdef TAWAS_RCN_LDQ_TIMEOUT_EN
            if (!hit) begin
                for (int k = 3; k >= 0; k--)
                    if (m_st[k] == 2 && (cyc - m_enter[k]) >= int'(TO)) c = k;
            end
`endif
            if (c >= 0) begin
                e.slice = 2'(c); e.sel = m_sel[c]; e.data = 32'hFFFF_FFFF; e.due = cyc + 1;
                sb.push_back(e);
                nx[c] = 0;
                m_et = 1'b1;
            end
            m_st = nx;
        end
    endtask

    task automatic idle(input logic ack);
        step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, ack, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic run_random(input int n);
        logic [1:0] wl[$];
        logic [1:0] pt;
        for (int i = 0; i < n; i++) begin
            wl.delete();
            for (int k = 0; k < 4; k++) if (m_st[k] == 2) wl.push_back(2'(k));
            pt = 2'($urandom_range(0, 3));
            if (wl.size() > 0 && $urandom_range(0, 9) < 7)
                pt = wl[$urandom_range(0, wl.size() - 1)];
            step($urandom_range(0, 299) != 0, $urandom_range(0, 9) < 4,
                 2'($urandom_range(0, 3)), 4'($urandom), $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, pt, $urandom);
        end
    endtask

    initial begin
        int k_hit;
        model_reset();
        repeat (2) @(posedge CLK);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(1'b0);
        chk("reset_rd_vld", RD_VLD, 1'b0);
        chk("reset_wb_vld", RCN_LOAD_VLD, 1'b0);

        // Single load on slice 2.
        step(1'b1, 1'b1, 2'd2, 4'd5, 32'h1000, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(1'b1);
        chk("t1_rd_tag", RD_TAG, 2'd2);
        chk("t1_rd_addr", RD_ADDR, 32'h1000);
        step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd2, 32'hCAFE_F00D);
        idle(1'b0);
        chk("t1_wb_vld", RCN_LOAD_VLD, 1'b1);
        chk("t1_wb_slice", RCN_LOAD_SLICE, 2'd2);
        chk("t1_wb_sel", RCN_LOAD_SEL, 4'd5);
        chk("t1_wb_data", RCN_LOAD, 32'hCAFE_F00D);
        chk("t1_pend2", SLICE_PEND[2], 1'b0);

        // Three requests, RD_ACK held off: grant must stay on slice 0, then 0,1,3 in order.
        step(1'b1, 1'b1, 2'd0, 4'd1, 32'h100, 1'b0, 1'b0, 2'd0, 32'd0);
        step(1'b1, 1'b1, 2'd1, 4'd2, 32'h200, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("t2_hold_tag", RD_TAG, 2'd0);
        step(1'b1, 1'b1, 2'd3, 4'd3, 32'h300, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("t2_hold_tag", RD_TAG, 2'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("t2_hold_vld", RD_VLD, 1'b1);
            chk("t2_hold_tag", RD_TAG, 2'd0);
        end
        idle(1'b1);
        chk("t2_grant0", RD_TAG, 2'd0);
        idle(1'b1);
        chk("t2_grant1", RD_TAG, 2'd1);
        idle(1'b1);
        chk("t2_grant3", RD_TAG, 2'd3);
        step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd0, 32'hA0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd1, 32'hA1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd3, 32'hA3);
        idle(1'b0);
        idle(1'b0);

        // Busy slice rejects a second request.
        step(1'b1, 1'b1, 2'd1, 4'd7, 32'h2000, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(1'b1);
        step(1'b1, 1'b1, 2'd1, 4'd9, 32'h3000, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(1'b0);
        chk("t3_err_busy", ERR_BUSY, 1'b1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd1, 32'h1111_2222);
        idle(1'b0);
        chk("t3_wb_vld", RCN_LOAD_VLD, 1'b1);
        chk("t3_wb_sel", RCN_LOAD_SEL, 4'd7);
        idle(1'b0);
        chk("t3_single_wb", RCN_LOAD_VLD, 1'b0);

        // Spurious response to an idle slice.
        step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd3, 32'h5555);
        idle(1'b0);
        chk("t4_err_spur", ERR_SPUR, 1'b1);
        chk("t4_no_wb", RCN_LOAD_VLD, 1'b0);

        // Reset while slice 0 waits abandons the load.
        step(1'b1, 1'b1, 2'd0, 4'd4, 32'h4000, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(1'b1);
        step(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(1'b0);
        chk("t5_pend", SLICE_PEND, 4'd0);
        chk("t5_rd_vld", RD_VLD, 1'b0);
        chk("t5_rd_addr", RD_ADDR, 32'd0);
        chk("t5_wb_slice", RCN_LOAD_SLICE, 2'd0);
        chk("t5_wb_sel", RCN_LOAD_SEL, 4'd0);
        chk("t5_wb_data", RCN_LOAD, 32'd0);
        chk("t5_err_busy", ERR_BUSY, 1'b0);
        chk("t5_err_spur", ERR_SPUR, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd0, 32'h7777);
        idle(1'b0);
        chk("t5_spur_after_rst", ERR_SPUR, 1'b1);
        chk("t5_no_wb", RCN_LOAD_VLD, 1'b0);

`ifdef TAWAS_RCN_LDQ_TIMEOUT_EN
        // No response: forced completion TO cycles after entering WAIT.
        step(1'b1, 1'b1, 2'd0, 4'd6, 32'h6000, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(1'b1);
        k_hit = 0;
        for (int i = 1; i <= 20; i++) begin
            idle(1'b0);
            if (RCN_LOAD_VLD && k_hit == 0) k_hit = i;
        end
        chk("t6_to_latency", k_hit, TO + 1);
        chk("t6_err_to", ERR_TO, 1'b1);
        chk("t6_to_data", RCN_LOAD, 32'hFFFF_FFFF);
`endif

        run_random(1500);
        repeat (4) idle(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
